scan_test_controller: RTL and testbench
=======================================

Name: scan_test_controller

Overview:
- Drives a DFF_ScanChain-style chain: generates scan_en and scan_in, observes scan_out.
- Per test, runs shift-in, capture, shift-out and compare, then reports the response and a pass/fail flag.
- Sits directly upstream and downstream of the scan chain, between the chain and the test sequencer or host registers.

Parameters:
- CHAIN_LEN, 8, number of scan flops in the chain (>= 2).
- CAPTURE_CYCLES, 1, functional-mode cycles (scan_en=0) between shift-in and shift-out (>= 1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the internal bit counter.

Ports:
- clk  in  1  rising-edge clock, shared with the chain.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request to run one test; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE, no done pulse.
- pattern_in  in  CHAIN_LEN  stimulus; bit CHAIN_LEN-1 is shifted first.
- expected  in  CHAIN_LEN  expected response, same bit order as response.
- scan_out  in  1  serial output of the last chain flop.
- scan_en  out  1  chain shift enable.
- scan_in  out  1  serial data into the first chain flop.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- response  out  CHAIN_LEN  captured response; first bit sampled ends in MSB.
- pass  out  1  (response == expected); valid from done, held until the next accepted start.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - scan_en, scan_in, busy, done, pass = 0.
  - response = 0.
  - Reset mid-test aborts immediately; the chain contents are not restored.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - scan_en=0.
  - On an edge with start=1 and abort=0: latch pattern_in and expected, clear pass, cnt=0, go to SHIFT_IN.
- SHIFT_IN:
  - scan_en=1; scan_in = pattern shift-register MSB.
  - Each edge: shift the register left, cnt++.
  - After CHAIN_LEN edges: go to CAPTURE, cnt=0.
- CAPTURE:
  - scan_en=0, scan_in=0, for exactly CAPTURE_CYCLES cycles; then go to SHIFT_OUT, cnt=0.
- SHIFT_OUT:
  - scan_en=1, scan_in=0.
  - Each edge: response <= {response[CHAIN_LEN-2:0], scan_out}, cnt++. scan_out is sampled before the same edge shifts the chain.
  - After CHAIN_LEN edges: go to DONE.
- DONE:
  - done=1 and pass updated, both for one cycle; then go to IDLE.
  - response and pass hold until the next accepted start.
- Latency: done rises 2*CHAIN_LEN+CAPTURE_CYCLES+1 edges after the edge that accepted start.
- Start handling: start while busy is ignored (not queued). start held high re-triggers on the cycle after DONE, giving back-to-back tests.
- Abort:
  - In any non-IDLE state: next edge goes to IDLE, scan_en=0, done=0, response and pass unchanged.
  - Abort has priority over start and over state completion.
- Bit order: pattern MSB first at scan_in, response MSB first from scan_out. With a pure shift register and no capture change, response equals pattern_in.
- Counters never wrap: cnt saturates at CHAIN_LEN, and reaching it forces the transition.

Optional Feature:
- Macro: SCAN_MASK_EN.
- Defined:
  - Adds input port mask [CHAIN_LEN-1:0], latched with expected at start.
  - pass = ((response ^ expected) & ~mask) == 0; mask bit 1 = don't care.
- Undefined:
  - No mask port; pass is an exact compare.

Decomposition:
- Package scan_ctrl_pkg holds:
  - the state enum typedef (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE, 3-bit encoding);
  - the localparam helper for CNT_W.
- One natural sub-module: scan_shift_reg, a parallel-load / serial-shift register, instantiated twice:
  - stimulus: parallel load, MSB serial out;
  - response: serial in at LSB, parallel out.

Test Plan:
- Loopback, CHAIN_LEN=4, chain model with D tied to its own Q in capture: pattern_in=4'b1011, expected=4'b1011 -> scan_in sequence 1,0,1,1; done at edge 10 after start; response=1011, pass=1.
- Capture change, chain model capturing D=4'b0110: pattern 1011, expected 0110 -> response=0110, pass=1. Same run with expected=0111 -> pass=0.
- Reset mid-SHIFT_IN: assert rst=0 at shift edge 2 -> scan_en, busy and done drop to 0 without waiting for a clock edge; after release, a new start runs a full test correctly.
- Abort during SHIFT_OUT -> IDLE next edge, no done pulse, response and pass keep their previous-test values. start pulsed during busy -> ignored, no second done.
- start held high across two tests with patterns 1011 then 0100 -> two done pulses exactly 11 cycles apart, with correct responses and pass for each.
- SCAN_MASK_EN defined: expected=0110, mask=0001, chain captures 0111 -> pass=1. Same run with mask=0000 -> pass=0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan test controller.
//   state_t   : controller FSM state, 3-bit encoding
//   cnt_width : width of a counter that must reach max(a, b)
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register, shifting towards the MSB.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : parallel load of load_val (wins over shift)
//   load_val  : parallel load value
//   shift     : shift left by one, shift_in enters at the LSB
//   shift_in  : serial input
//   q         : register contents (q[W-1] is the serial output)
module scan_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan test controller: shifts a pattern into a scan chain, runs capture
// cycles, shifts the response out and compares it with the expected value.
// Optional build macro: SCAN_MASK_EN adds a don't-care mask on the compare.
// Ports:
//   clk, rst    : clock shared with the chain, asynchronous active-low reset
//   start       : run one test (sampled only in IDLE)
//   abort       : synchronous abort back to IDLE, no done pulse
//   pattern_in  : stimulus, MSB shifted first
//   expected    : expected response
//   mask        : (SCAN_MASK_EN only) 1 = ignore that response bit
//   scan_out    : serial output of the last chain flop
//   scan_en     : chain shift enable
//   scan_in     : serial data into the first chain flop
//   busy        : high outside IDLE
//   done        : one-cycle completion pulse
//   response    : last completed response, first sampled bit in MSB
//   pass        : compare result, valid from done until next accepted start
//
// state     | meaning
// IDLE      | waiting for start
// SHIFT_IN  | shifting pattern into the chain, scan_en=1
// CAPTURE   | functional cycles, scan_en=0
// SHIFT_OUT | shifting response out of the chain, scan_en=1
// DONE      | publish response/pass, pulse done
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1,
  parameter int CNT_W          = cnt_width(CHAIN_LEN, CAPTURE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_MASK_EN
  input  logic [CHAIN_LEN-1:0] mask,
`endif
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 last_shift;
  logic                 last_cap;
  logic                 accept;
  logic                 kill;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] stim_q;
  logic [CHAIN_LEN-1:0] resp_q;
  logic                 miscompare;
  logic                 unused_stim_bits;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign last_shift = (cnt_inc == CNT_W'(CHAIN_LEN));
  assign last_cap   = (cnt_inc == CNT_W'(CAPTURE_CYCLES));
  assign accept     = (state == IDLE) && start && !abort;
  assign kill       = (state != IDLE) && abort;

  // The stimulus register drains to zero after CHAIN_LEN shifts and is
  // cleared on abort, so its MSB flop can drive scan_in directly and is 0
  // outside SHIFT_IN.
  scan_shift_reg #(.W(CHAIN_LEN)) u_stim (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || kill),
    .load_val (accept ? pattern_in : '0),
    .shift    ((state == SHIFT_IN) && !abort),
    .shift_in (1'b0),
    .q        (stim_q)
  );

  // Working response; the published response is only updated in DONE so an
  // aborted test leaves the previous result visible.
  scan_shift_reg #(.W(CHAIN_LEN)) u_resp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .shift    ((state == SHIFT_OUT) && !abort),
    .shift_in (scan_out),
    .q        (resp_q)
  );

  assign scan_in          = stim_q[CHAIN_LEN-1];
  assign unused_stim_bits = ^stim_q[CHAIN_LEN-2:0];

`ifdef SCAN_MASK_EN
  logic [CHAIN_LEN-1:0] mask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= mask;
    end
  end

  assign miscompare = |((resp_q ^ exp_q) & ~mask_q);
`else
  assign miscompare = |(resp_q ^ exp_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      scan_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      response <= '0;
      exp_q    <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state   <= IDLE;
        cnt     <= '0;
        scan_en <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= SHIFT_IN;
              cnt     <= '0;
              scan_en <= 1'b1;
              busy    <= 1'b1;
              exp_q   <= expected;
              pass    <= 1'b0;
            end
          end
          SHIFT_IN: begin
            if (last_shift) begin
              state   <= CAPTURE;
              cnt     <= '0;
              scan_en <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          CAPTURE: begin
            if (last_cap) begin
              state   <= SHIFT_OUT;
              cnt     <= '0;
              scan_en <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          SHIFT_OUT: begin
            if (last_shift) begin
              state   <= DONE;
              cnt     <= '0;
              scan_en <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          DONE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= !miscompare;
            response <= resp_q;
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            scan_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_test_controller.sv
module tb_scan_test_controller;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic [N-1:0] expected = '0;
`ifdef SCAN_MASK_EN
  logic [N-1:0] mask = '0;
`endif
  logic         scan_out;
  logic         scan_en;
  logic         scan_in;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] response;

  // Chain model: shifts when scan_en, otherwise holds (cap_mode=0) or
  // captures cap_d (cap_mode=1).
  logic [N-1:0] chain_q = '0;
  logic         cap_mode = 1'b0;
  logic [N-1:0] cap_d = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
    else if (cap_mode) chain_q <= cap_d;
  end
  assign scan_out = chain_q[N-1];

  scan_test_controller #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pattern_in (pattern_in),
    .expected   (expected),
`ifdef SCAN_MASK_EN
    .mask       (mask),
`endif
    .scan_out   (scan_out),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .pass       (pass)
  );

  // Starts one test and reports the negedge index (1 = first negedge after
  // the accepting edge) at which done was seen, plus response and pass.
  task automatic run_one(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                         output int done_at, output logic [N-1:0] resp, output logic p);
    @(negedge clk);
    pattern_in = pat;
    expected   = exp_v;
    start      = 1'b1;
    done_at    = -1;
    resp       = '0;
    p          = 1'b0;
    for (int i = 1; i <= 30 && done_at < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_at = i;
        resp    = response;
        p       = pass;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL reset_scan_en got %b want 0", scan_en); end
    checks++; if (scan_in !== 1'b0) begin errors++; $display("FAIL reset_scan_in got %b want 0", scan_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (response !== 4'b0000) begin errors++; $display("FAIL reset_response got %b want 0000", response); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [N-1:0] pat;
    logic [N-1:0] exp_in;
    pat      = 4'b1011;
    cap_mode = 1'b0;
    @(negedge clk);
    pattern_in = pat;
    expected   = pat;
    start      = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b want 1", busy); end
      end
      if (i <= 4) begin
        exp_in = pat >> (4 - i);
        checks++; if (scan_in !== exp_in[0]) begin errors++; $display("FAIL loop_scan_in[%0d] got %b want %b", i, scan_in, exp_in[0]); end
        checks++; if (scan_en !== 1'b1) begin errors++; $display("FAIL loop_scan_en_shift[%0d] got %b want 1", i, scan_en); end
      end
      if (i == 5) begin
        checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL loop_scan_en_capture got %b want 0", scan_en); end
      end
      if (i == 6) begin
        checks++; if (scan_en !== 1'b1 || scan_in !== 1'b0) begin errors++; $display("FAIL loop_shift_out_en got en=%b in=%b want en=1 in=0", scan_en, scan_in); end
      end
      if (i < 11 || i == 12) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done_low[%0d] got %b want 0", i, done); end
      end
      if (i == 11) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL loop_done_edge10 got %b want 1", done); end
        checks++; if (response !== 4'b1011) begin errors++; $display("FAIL loop_response got %b want 1011", response); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL loop_pass got %b want 1", pass); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_done got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_busy_start();
    int n_done;
    int first_at;
    cap_mode = 1'b0;
    n_done   = 0;
    first_at = -1;
    @(negedge clk);
    pattern_in = 4'b1101;
    expected   = 4'b1101;
    start      = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 4);
      if (done) begin
        n_done++;
        if (first_at < 0) first_at = i;
      end
    end
    start = 1'b0;
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", n_done); end
    checks++; if (first_at !== 11) begin errors++; $display("FAIL busy_start_latency got %0d want 11", first_at); end
    checks++; if (response !== 4'b1101) begin errors++; $display("FAIL busy_start_response got %b want 1101", response); end
  endtask

  task automatic test_capture();
    int           d_at;
    logic [N-1:0] r;
    logic         p;
    cap_mode = 1'b1;
    cap_d    = 4'b0110;
    run_one(4'b1011, 4'b0110, d_at, r, p);
    checks++; if (d_at !== 11) begin errors++; $display("FAIL cap_latency got %0d want 11", d_at); end
    checks++; if (r !== 4'b0110) begin errors++; $display("FAIL cap_response got %b want 0110", r); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL cap_pass got %b want 1", p); end
    @(negedge clk);
    pattern_in = 4'b1011;
    expected   = 4'b0111;
    start      = 1'b1;
    d_at = -1;
    for (int i = 1; i <= 30 && d_at < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL cap_pass_cleared got %b want 0", pass); end
      end
      if (done) begin
        d_at = i;
        checks++; if (response !== 4'b0110) begin errors++; $display("FAIL cap2_response got %b want 0110", response); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL cap2_pass got %b want 0", pass); end
      end
    end
    checks++; if (d_at !== 11) begin errors++; $display("FAIL cap2_latency got %0d want 11", d_at); end
    cap_mode = 1'b0;
  endtask

  task automatic test_abort();
    int n_done;
    n_done   = 0;
    cap_mode = 1'b0;
    @(negedge clk);
    pattern_in = 4'b1001;
    expected   = 4'b1001;
    start      = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      if (i == 6) begin
        checks++; if (scan_en !== 1'b1) begin errors++; $display("FAIL abort_in_shift_out got %b want 1", scan_en); end
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL abort_scan_en got %b want 0", scan_en); end
    checks++; if (response !== 4'b0110) begin errors++; $display("FAIL abort_response got %b want 0110", response); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got %b want 0", pass); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int at1;
    int at2;
    n_done   = 0;
    at1      = -1;
    at2      = -1;
    cap_mode = 1'b0;
    @(negedge clk);
    pattern_in = 4'b1011;
    expected   = 4'b1011;
    start      = 1'b1;
    for (int i = 1; i <= 40 && n_done < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        pattern_in = 4'b0100;
        expected   = 4'b0101;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          at1 = i;
          checks++; if (response !== 4'b1011 || pass !== 1'b1) begin errors++; $display("FAIL b2b_first got resp=%b pass=%b want resp=1011 pass=1", response, pass); end
        end else begin
          at2   = i;
          start = 1'b0;
          checks++; if (response !== 4'b0100 || pass !== 1'b0) begin errors++; $display("FAIL b2b_second got resp=%b pass=%b want resp=0100 pass=0", response, pass); end
        end
      end
    end
    start = 1'b0;
    checks++; if (at1 !== 11) begin errors++; $display("FAIL b2b_first_latency got %0d want 11", at1); end
    checks++; if (at2 - at1 !== 11) begin errors++; $display("FAIL b2b_spacing got %0d want 11", at2 - at1); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third got busy=%b want 0", busy); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int           d_at;
    logic [N-1:0] r;
    logic         p;
    cap_mode = 1'b0;
    @(negedge clk);
    pattern_in = 4'b1011;
    expected   = 4'b1011;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (scan_en !== 1'b0) begin errors++; $display("FAIL rst_mid_scan_en got %b want 0", scan_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
    @(negedge clk);
    rst = 1'b1;
    run_one(4'b1011, 4'b1011, d_at, r, p);
    checks++; if (d_at !== 11) begin errors++; $display("FAIL rst_rerun_latency got %0d want 11", d_at); end
    checks++; if (r !== 4'b1011 || p !== 1'b1) begin errors++; $display("FAIL rst_rerun got resp=%b pass=%b want resp=1011 pass=1", r, p); end
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    int           d_at;
    logic [N-1:0] r;
    logic         p;
    cap_mode = 1'b1;
    cap_d    = 4'b0111;
    mask     = 4'b0001;
    run_one(4'b1011, 4'b0110, d_at, r, p);
    checks++; if (r !== 4'b0111 || p !== 1'b1) begin errors++; $display("FAIL mask_dont_care got resp=%b pass=%b want resp=0111 pass=1", r, p); end
    mask = 4'b0000;
    run_one(4'b1011, 4'b0110, d_at, r, p);
    checks++; if (r !== 4'b0111 || p !== 1'b0) begin errors++; $display("FAIL mask_none got resp=%b pass=%b want resp=0111 pass=0", r, p); end
    cap_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_busy_start();
    test_capture();
    test_abort();
    test_back_to_back();
    test_abort_idle();
    test_reset_mid();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
